sprite_compositor: RTL

Parametrised, pipelined layer compositor with pixel-accurate collision detection. It is the successor to the fixed 10-layer priority mux in the game top level. It takes N sprite/background layers, each with an on bit and an RGB value, and selects the highest-priority visible layer per pixel over two registered stages. It also detects per-pixel overlap between a designated player layer and a configurable set of hazard layers, and reports it as a per-frame snapshot, a sticky flag and a saturating frame counter.

---
 rtl/compositor_pkg.sv | 17 +
 rtl/priority_select.sv | 30 +++
 rtl/sprite_compositor.sv | 130 +++++++++++++
 3 files changed

// File: rtl/compositor_pkg.sv
// ============================================================================
//  Module   : compositor_pkg
//  Purpose  : Shared defaults and layer index constants for sprite_compositor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package compositor_pkg;
    localparam int c_N_LAYERS   = 10;
    localparam int c_PIX_W      = 3;
    localparam int c_CNT_W      = 8;
    localparam int LAYER_BG     = 0;
    localparam int LAYER_PLAYER = c_N_LAYERS - 1;
    localparam int c_KEY_COLOR  = 0;
endpackage

`default_nettype wire

// File: rtl/priority_select.sv
// ============================================================================
//  Module   : priority_select
//  Purpose  : Combinational N-way picker; highest-index active layer wins.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_select #(
    parameter int N = 10,
    parameter int W = 3
) (
    input  logic [N-1:0]   i_on,
    input  logic [N*W-1:0] i_rgb,
    output logic [W-1:0]   o_rgb,
    output logic           o_any_on
);

    // Later iterations overwrite earlier ones, so the highest index wins.
    always_comb begin
        o_rgb = '0;
        for (int i = 0; i < N; i++) begin
            if (i_on[i]) o_rgb = i_rgb[i*W +: W];
        end
    end

    assign o_any_on = |i_on;

endmodule

`default_nettype wire

// File: rtl/sprite_compositor.sv
// ============================================================================
//  Module   : sprite_compositor
//  Purpose  : Two-stage layer compositor with player/hazard collision tracking.
//             Macro COMPOSITOR_TRANSPARENCY_EN treats KEY_COLOR pixels as off.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_compositor
    import compositor_pkg::*;
#(
    parameter int                    N_LAYERS   = c_N_LAYERS,
    parameter int                    PIX_W      = c_PIX_W,
    parameter int                    PLAYER_IDX = N_LAYERS - 1,
    parameter logic [N_LAYERS-1:0]   COLL_MASK  = ~((N_LAYERS'(1) << PLAYER_IDX) |
                                                    (N_LAYERS'(1) << LAYER_BG)),
    parameter logic [PIX_W-1:0]      KEY_COLOR  = PIX_W'(c_KEY_COLOR),
    parameter int                    CNT_W      = c_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      video_on,
    input  logic                      frame_start,
    input  logic [N_LAYERS-1:0]       on_objs,
    input  logic [N_LAYERS*PIX_W-1:0] rgb_objs,
    input  logic                      coll_clr,
    output logic [PIX_W-1:0]          rgb_out,
    output logic                      video_on_out,
    output logic [N_LAYERS-1:0]       coll_layers,
    output logic                      coll_valid,
    output logic                      colision,
    output logic [CNT_W-1:0]          coll_frames
);

`ifdef COMPOSITOR_TRANSPARENCY_EN
    localparam bit c_TRANSP_EN = 1'b1;
`else
    localparam bit c_TRANSP_EN = 1'b0;
`endif

    logic                      r_vid_d1;
    logic                      r_fs_d1;
    logic [N_LAYERS-1:0]       r_on_d1;
    logic [N_LAYERS*PIX_W-1:0] r_rgb_d1;

    logic [PIX_W-1:0]          r_rgb_out;
    logic                      r_vid_out;
    logic [N_LAYERS-1:0]       r_acc;
    logic [N_LAYERS-1:0]       r_coll_layers;
    logic                      r_coll_valid;
    logic                      r_colision;
    logic [CNT_W-1:0]          r_coll_frames;

    logic [N_LAYERS-1:0]       w_eff_on;
    logic [N_LAYERS-1:0]       w_hit;
    logic [N_LAYERS-1:0]       w_snap;
    logic [PIX_W-1:0]          w_sel_rgb;
    logic                      w_any_on;

    for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_eff_on
        assign w_eff_on[gi] = r_on_d1[gi] &
                              (!c_TRANSP_EN || (r_rgb_d1[gi*PIX_W +: PIX_W] != KEY_COLOR));
    end

    assign w_hit  = {N_LAYERS{w_eff_on[PLAYER_IDX] & r_vid_d1}} & w_eff_on & COLL_MASK;
    // A hit coinciding with frame_start closes out the finishing frame.
    assign w_snap = r_acc | w_hit;

    priority_select #(
        .N (N_LAYERS),
        .W (PIX_W)
    ) u_priority_select (
        .i_on     (w_eff_on),
        .i_rgb    (r_rgb_d1),
        .o_rgb    (w_sel_rgb),
        .o_any_on (w_any_on)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vid_d1      <= 1'b0;
            r_fs_d1       <= 1'b0;
            r_on_d1       <= '0;
            r_rgb_d1      <= '0;
            r_rgb_out     <= '0;
            r_vid_out     <= 1'b0;
            r_acc         <= '0;
            r_coll_layers <= '0;
            r_coll_valid  <= 1'b0;
            r_colision    <= 1'b0;
            r_coll_frames <= '0;
        end else begin
            r_vid_d1     <= video_on;
            r_fs_d1      <= frame_start;
            r_on_d1      <= on_objs;
            r_rgb_d1     <= rgb_objs;

            r_rgb_out    <= (r_vid_d1 && w_any_on) ? w_sel_rgb : '0;
            r_vid_out    <= r_vid_d1;
            r_coll_valid <= r_fs_d1;

            if (r_fs_d1) begin
                r_coll_layers <= w_snap;
                r_acc         <= '0;
                if (|w_snap && (r_coll_frames != {CNT_W{1'b1}}))
                    r_coll_frames <= r_coll_frames + CNT_W'(1);
            end else begin
                r_acc <= w_snap;
            end

            // coll_clr acts on the hit being registered this cycle and overrides it.
            if (coll_clr) begin
                r_colision    <= 1'b0;
                r_coll_frames <= '0;
            end else if (|w_hit) begin
                r_colision    <= 1'b1;
            end
        end
    end

    assign rgb_out      = r_rgb_out;
    assign video_on_out = r_vid_out;
    assign coll_layers  = r_coll_layers;
    assign coll_valid   = r_coll_valid;
    assign colision     = r_colision;
    assign coll_frames  = r_coll_frames;

endmodule

`default_nettype wire
